// File: rtl/mux_recirc_sync_rx.sv
// Destination-side receiver for the mux-recirculation CDC scheme: synchronises the source request,
// captures the quasi-static source bus through a recirculating hold register, and returns an ack.
module mux_recirc_sync_rx #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int MODE        = 1
) (
   input  logic             c2,
   input  logic             rstn,
   input  logic [WIDTH-1:0] src_data,
   input  logic             src_req,
   output logic             src_ack,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun,
   input  logic             overrun_clr
);

   if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("mux_recirc_sync_rx: SYNC_STAGES must be >= 2");
   end

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_req_s_d;
   logic                   r_ack_q;
   logic                   r_valid;
   logic                   r_overrun;
   logic [WIDTH-1:0]       r_data;

   logic w_req_s;
   logic w_capture;
   logic w_overrun_set;

   assign w_req_s = r_sync[SYNC_STAGES-1];

   // Toggle mode only loads when the slot is free or being drained; level mode loads on every rise.
   always_comb begin
      w_capture     = 1'b0;
      w_overrun_set = 1'b0;
      if (MODE == 1) begin
         w_capture = (w_req_s != r_ack_q) && (!r_valid || out_ready);
      end else begin
         w_capture     = w_req_s && !r_req_s_d;
         w_overrun_set = w_capture && r_valid && !out_ready;
      end
   end

   always_ff @(posedge c2) begin
      if (!rstn) begin
         r_sync    <= '0;
         r_req_s_d <= 1'b0;
         r_ack_q   <= 1'b0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
         r_data    <= '0;
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], src_req};
         r_req_s_d <= w_req_s;
         if (w_capture) begin
            r_ack_q <= w_req_s;
            r_valid <= 1'b1;
            r_data  <= src_data;
         end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
         end
         if (w_overrun_set) begin
            r_overrun <= 1'b1;
         end else if (overrun_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign src_ack   = (MODE == 1) ? r_ack_q : r_req_s_d;
   assign out_data  = r_data;
   assign out_valid = r_valid;
   assign overrun   = (MODE == 1) ? 1'b0 : r_overrun;

endmodule

// File: tb/tb_mux_recirc_sync_rx.sv
// Bench for mux_recirc_sync_rx: four parameter sets driven in parallel, directed scenarios plus
// random traffic, each instance compared every cycle against a request-history reference model.
module tb_mux_recirc_sync_rx;

   localparam int N = 4;

   function automatic int cfg_w(input int i);
      case (i)
         0: return 8;
         1: return 8;
         2: return 32;
         default: return 1;
      endcase
   endfunction

   function automatic int cfg_s(input int i);
      return (i < 2) ? 2 : 4;
   endfunction

   function automatic int cfg_m(input int i);
      return (i % 2 == 0) ? 1 : 0;
   endfunction

   logic        clk = 1'b0;
   logic        rstn;
   logic        src_req;
   logic        out_ready;
   logic        overrun_clr;
   logic [31:0] src_data;
   bit          chk_en;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      localparam int W = cfg_w(gi);
      localparam int S = cfg_s(gi);
      localparam int M = cfg_m(gi);

      logic [W-1:0] w_data;
      logic         w_valid;
      logic         w_ack;
      logic         w_ovr;

      mux_recirc_sync_rx #(.WIDTH(W), .SYNC_STAGES(S), .MODE(M)) u_dut (
         .c2          (clk),
         .rstn        (rstn),
         .src_data    (src_data[W-1:0]),
         .src_req     (src_req),
         .src_ack     (w_ack),
         .out_data    (w_data),
         .out_valid   (w_valid),
         .out_ready   (out_ready),
         .overrun     (w_ovr),
         .overrun_clr (overrun_clr)
      );

      // hist holds src_req as seen at each edge since reset; req_s is the sample S edges back.
      bit           hist[$];
      bit           m_valid;
      bit           m_ack;
      bit           m_src_ack;
      bit           m_ovr;
      logic [W-1:0] m_data;

      always @(posedge clk) begin
         bit rq;
         bit rqd;
         bit cap;
         if (!rstn) begin
            hist.delete();
            for (int k = 0; k <= S; k++) hist.push_back(1'b0);
            m_valid   = 1'b0;
            m_ack     = 1'b0;
            m_src_ack = 1'b0;
            m_ovr     = 1'b0;
            m_data    = '0;
         end else begin
            rq  = hist[hist.size() - S];
            rqd = hist[hist.size() - S - 1];
            if (M == 1) cap = (rq != m_ack) && (!m_valid || out_ready);
            else        cap = rq && !rqd;
            if (M == 0 && cap && m_valid && !out_ready) m_ovr = 1'b1;
            else if (overrun_clr)                       m_ovr = 1'b0;
            if (cap) begin
               m_data  = src_data[W-1:0];
               m_valid = 1'b1;
               m_ack   = rq;
            end else if (m_valid && out_ready) begin
               m_valid = 1'b0;
            end
            m_src_ack = (M == 1) ? m_ack : rq;
            hist.push_back(src_req);
            if (hist.size() > 32) void'(hist.pop_front());
         end
      end

      always @(negedge clk) begin
         if (chk_en) begin
            check_eq($sformatf("i%0d valid", gi), 32'(w_valid), 32'(m_valid));
            check_eq($sformatf("i%0d data", gi),  32'(w_data),  32'(m_data));
            check_eq($sformatf("i%0d ack", gi),   32'(w_ack),   32'(m_src_ack));
            check_eq($sformatf("i%0d ovr", gi),   32'(w_ovr),   32'(m_ovr));
         end
      end
   end

   initial begin
      int lat [N];
      int loads;
      rstn        = 1'b0;
      src_req     = 1'b1;
      src_data    = 32'hFF;
      out_ready   = 1'b0;
      overrun_clr = 1'b0;
      for (int k = 0; k < N; k++) lat[k] = -1;
      @(negedge clk);
      chk_en = 1'b1;

      // Reset held with the request high: nothing may leak out.
      repeat (3) begin
         tick();
         check_eq("rst valid", 32'(g_dut[0].w_valid), 32'd0);
         check_eq("rst data",  32'(g_dut[0].w_data),  32'd0);
         check_eq("rst ack",   32'(g_dut[0].w_ack),   32'd0);
         check_eq("rst ovr",   32'(g_dut[1].w_ovr),   32'd0);
      end
      rstn = 1'b1;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (lat[0] < 0 && g_dut[0].w_valid) lat[0] = t;
         if (lat[1] < 0 && g_dut[1].w_valid) lat[1] = t;
         if (lat[2] < 0 && g_dut[2].w_valid) lat[2] = t;
         if (lat[3] < 0 && g_dut[3].w_valid) lat[3] = t;
      end
      check_eq("lat w8s2m1",  32'(lat[0]), 32'd3);
      check_eq("lat w8s2m0",  32'(lat[1]), 32'd3);
      check_eq("lat w32s4m1", 32'(lat[2]), 32'd5);
      check_eq("lat w1s4m0",  32'(lat[3]), 32'd5);
      check_eq("rst cap data",   32'(g_dut[0].w_data),  32'hFF);
      check_eq("rst cap valid",  32'(g_dut[0].w_valid), 32'd1);
      check_eq("rst cap data32", 32'(g_dut[2].w_data),  32'hFF);
      check_eq("rst cap data1",  32'(g_dut[3].w_data),  32'd1);

      src_req = 1'b0;
      rstn    = 1'b0;
      repeat (2) tick();
      rstn      = 1'b1;
      out_ready = 1'b1;
      repeat (6) tick();

      // Toggle mode, consumer always ready.
      src_data = 32'hA5;
      src_req  = 1'b1;
      tick();
      tick();
      check_eq("m1 early valid", 32'(g_dut[0].w_valid), 32'd0);
      tick();
      check_eq("m1 valid", 32'(g_dut[0].w_valid), 32'd1);
      check_eq("m1 data",  32'(g_dut[0].w_data),  32'hA5);
      check_eq("m1 ack",   32'(g_dut[0].w_ack),   32'd1);
      tick();
      check_eq("m1 drop",  32'(g_dut[0].w_valid), 32'd0);

      // Toggle mode backpressure: second word waits for the slot.
      out_ready = 1'b0;
      src_data  = 32'h11;
      src_req   = 1'b0;
      repeat (3) tick();
      check_eq("bp first data", 32'(g_dut[0].w_data), 32'h11);
      check_eq("bp first ack",  32'(g_dut[0].w_ack),  32'd0);
      src_data = 32'h22;
      src_req  = 1'b1;
      repeat (5) tick();
      check_eq("bp held ack",   32'(g_dut[0].w_ack),   32'd0);
      check_eq("bp held data",  32'(g_dut[0].w_data),  32'h11);
      check_eq("bp held valid", 32'(g_dut[0].w_valid), 32'd1);
      out_ready = 1'b1;
      tick();
      check_eq("bp swap data",  32'(g_dut[0].w_data),  32'h22);
      check_eq("bp swap valid", 32'(g_dut[0].w_valid), 32'd1);
      check_eq("bp swap ack",   32'(g_dut[0].w_ack),   32'd1);
      tick();
      check_eq("bp drain", 32'(g_dut[0].w_valid), 32'd0);

      // Level mode: a long high pulse loads once.
      src_req = 1'b0;
      repeat (5) tick();
      src_data = 32'h3C;
      src_req  = 1'b1;
      loads    = 0;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (g_dut[1].w_valid) loads++;
         if (t == 2) check_eq("m0 ack early", 32'(g_dut[1].w_ack), 32'd0);
         if (t == 3) begin
            check_eq("m0 ack", 32'(g_dut[1].w_ack), 32'd1);
            check_eq("m0 data", 32'(g_dut[1].w_data), 32'h3C);
         end
      end
      check_eq("m0 loads", 32'(loads), 32'd1);
      check_eq("m0 ack held", 32'(g_dut[1].w_ack), 32'd1);
      src_req = 1'b0;
      repeat (3) tick();
      check_eq("m0 ack fall", 32'(g_dut[1].w_ack), 32'd0);

      // Level mode overrun, clear, and clear colliding with a new overrun.
      out_ready = 1'b0;
      src_data  = 32'h01;
      src_req   = 1'b1;
      repeat (4) tick();
      check_eq("ovr first", 32'(g_dut[1].w_ovr), 32'd0);
      src_req = 1'b0;
      repeat (4) tick();
      src_data = 32'h02;
      src_req  = 1'b1;
      repeat (4) tick();
      check_eq("ovr data", 32'(g_dut[1].w_data), 32'h02);
      check_eq("ovr set",  32'(g_dut[1].w_ovr),  32'd1);
      check_eq("ovr m1",   32'(g_dut[0].w_ovr),  32'd0);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      check_eq("ovr clr", 32'(g_dut[1].w_ovr), 32'd0);
      src_req = 1'b0;
      repeat (4) tick();
      src_data = 32'h03;
      src_req  = 1'b1;
      tick();
      tick();
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      check_eq("ovr set wins", 32'(g_dut[1].w_ovr), 32'd1);
      tick();
      check_eq("ovr sticky", 32'(g_dut[1].w_ovr), 32'd1);

      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(3) == 0) src_req = ~src_req;
         if ($urandom_range(1) == 0) src_data = $urandom;
         out_ready   = 1'($urandom_range(1));
         overrun_clr = ($urandom_range(15) == 0);
         rstn        = ($urandom_range(499) != 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
